mandelbrot_result_collector: RTL and testbench

//  Receiving end of the engine result interface: detects each completed pixel from one

---
 rtl/mandelbrot_result_collector_if.sv | 46 ++++
 rtl/mandelbrot_result_collector.sv | 115 +++++++++++
 tb/tb_mandelbrot_result_collector.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_result_collector_if.sv
// -----------------------------------------------------------------------------
// mandelbrot_result_collector_if
//   Groups everything the result collector exchanges with its neighbours:
//   - engine side : finished / iterations / xpixel / ypixel in, full_queue out
//   - stream side : out_valid / out_ready handshake plus head pixel data
//   - control     : clear (synchronous flush)
//   - status      : overflow (sticky drop flag), count (FIFO occupancy)
//   Modports:
//     slave  - the collector itself (receives results, sources the stream)
//     master - the environment (engine + downstream consumer)
// -----------------------------------------------------------------------------
interface mandelbrot_result_collector_if #(
  parameter int PIXEL_DATA_WIDTH = 32,
  parameter int ITERATIONS_WIDTH = 32,
  parameter int DEPTH            = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                        clear;
  logic                        finished;
  logic [ITERATIONS_WIDTH-1:0] iterations;
  logic [PIXEL_DATA_WIDTH-1:0] xpixel;
  logic [PIXEL_DATA_WIDTH-1:0] ypixel;
  logic                        full_queue;
  logic                        out_valid;
  logic                        out_ready;
  logic [ITERATIONS_WIDTH-1:0] out_iterations;
  logic [PIXEL_DATA_WIDTH-1:0] out_x;
  logic [PIXEL_DATA_WIDTH-1:0] out_y;
  logic                        out_sof;
  logic                        out_eof;
  logic                        overflow;
  logic [CW-1:0]               count;

  modport slave (
    input  clear, finished, iterations, xpixel, ypixel, out_ready,
    output full_queue, out_valid, out_iterations, out_x, out_y,
           out_sof, out_eof, overflow, count
  );

  modport master (
    output clear, finished, iterations, xpixel, ypixel, out_ready,
    input  full_queue, out_valid, out_iterations, out_x, out_y,
           out_sof, out_eof, overflow, count
  );
endinterface

// File: rtl/mandelbrot_result_collector.sv
// -----------------------------------------------------------------------------
// mandelbrot_result_collector
//   Captures each completed pixel from a mandelbrot_engine (one push per rising
//   edge of finished), buffers it in a first-word-fall-through FIFO and drains
//   it as a valid/ready pixel stream. Start/end-of-frame flags are decoded
//   from the head pixel coordinates.
//   Ports:
//     clk    - single clock, all logic on posedge
//     reset  - asynchronous, active-high; empties the FIFO immediately
//     bus    - mandelbrot_result_collector_if.slave (engine inputs, backpressure,
//              output stream, clear, overflow, count)
// -----------------------------------------------------------------------------
module mandelbrot_result_collector #(
  parameter int PIXEL_DATA_WIDTH = 32,
  parameter int ITERATIONS_WIDTH = 32,
  parameter int DEPTH            = 16,
  parameter int FULL_MARGIN      = 2,
  parameter int SCREEN_WIDTH     = 1280,
  parameter int SCREEN_HEIGHT    = 720
) (
  input logic                          clk,
  input logic                          reset,
  mandelbrot_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - FULL_MARGIN);

  localparam logic [PIXEL_DATA_WIDTH-1:0] LAST_X = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] LAST_Y = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

  typedef struct packed {
    logic [ITERATIONS_WIDTH-1:0] iterations;
    logic [PIXEL_DATA_WIDTH-1:0] x;
    logic [PIXEL_DATA_WIDTH-1:0] y;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_fin_q;
  logic          r_full_queue;
  logic          r_overflow;

  logic          w_push_req;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_out_valid;
  logic [CW-1:0] w_count_next;
  entry_t        w_head;

  // Edge detect: a level-high finished yields one push only. r_fin_q resets
  // to 1 so a finished already high at reset release is not mistaken for a result.
  assign w_push_req  = bus.finished & ~r_fin_q;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok   = w_push_req & ((r_count != DEPTH_C) | w_pop);

  always_comb begin
    w_count_next = r_count;
    if (bus.clear)              w_count_next = '0;
    else if (w_push_ok && !w_pop) w_count_next = r_count + CW'(1);
    else if (!w_push_ok && w_pop) w_count_next = r_count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_fin_q      <= 1'b1;
      r_full_queue <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_fin_q      <= bus.finished;
      r_count      <= w_count_next;
      // Registered; the margin covers the engine's one-cycle reaction time.
      r_full_queue <= (w_count_next >= THRESH_C);
      if (bus.clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately not reset; out_valid=0 whenever count=0,
  // so stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (!bus.clear && w_push_ok) begin
      r_mem[r_wr_ptr] <= '{iterations: bus.iterations, x: bus.xpixel, y: bus.ypixel};
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.out_valid      = w_out_valid;
  assign bus.out_iterations = w_head.iterations;
  assign bus.out_x          = w_head.x;
  assign bus.out_y          = w_head.y;
  assign bus.out_sof        = w_out_valid && (w_head.x == '0)   && (w_head.y == '0);
  assign bus.out_eof        = w_out_valid && (w_head.x == LAST_X) && (w_head.y == LAST_Y);
  assign bus.full_queue     = r_full_queue;
  assign bus.overflow       = r_overflow;
  assign bus.count          = r_count;
endmodule

// File: tb/tb_mandelbrot_result_collector.sv
// -----------------------------------------------------------------------------
// tb_mandelbrot_result_collector
//   Self-checking bench: a queue-based model of the collector is compared with
//   the DUT on every falling clock edge; directed scenarios add literal
//   expectations, followed by a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_mandelbrot_result_collector;
  localparam int PW          = 32;
  localparam int IW          = 32;
  localparam int DEPTH       = 16;
  localparam int FULL_MARGIN = 2;
  localparam int SW          = 1280;
  localparam int SH          = 720;

  typedef struct {
    logic [IW-1:0] it;
    logic [PW-1:0] x;
    logic [PW-1:0] y;
  } pix_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mandelbrot_result_collector_if #(
    .PIXEL_DATA_WIDTH(PW), .ITERATIONS_WIDTH(IW), .DEPTH(DEPTH)
  ) bus ();

  mandelbrot_result_collector #(
    .PIXEL_DATA_WIDTH(PW), .ITERATIONS_WIDTH(IW), .DEPTH(DEPTH),
    .FULL_MARGIN(FULL_MARGIN), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  pix_t mq[$];
  bit   m_fin  = 1'b1;
  bit   m_ovf  = 1'b0;
  bit   m_full = 1'b0;

  always @(posedge clk or posedge reset) begin
    bit   rise;
    pix_t p;
    if (reset) begin
      mq.delete();
      m_fin  = 1'b1;
      m_ovf  = 1'b0;
      m_full = 1'b0;
    end else begin
      rise = bus.finished && !m_fin;
      if (bus.clear) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
        if (rise) begin
          if (mq.size() < DEPTH) begin
            p.it = bus.iterations; p.x = bus.xpixel; p.y = bus.ypixel;
            mq.push_back(p);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      m_full = (mq.size() >= DEPTH - FULL_MARGIN);
      m_fin  = bus.finished;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    check("count", 64'(bus.count), 64'(mq.size()));
    check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    check("full_queue", 64'(bus.full_queue), 64'(m_full));
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
    if (mq.size() != 0) begin
      check("out_iterations", 64'(bus.out_iterations), 64'(mq[0].it));
      check("out_x", 64'(bus.out_x), 64'(mq[0].x));
      check("out_y", 64'(bus.out_y), 64'(mq[0].y));
      check("out_sof", 64'(bus.out_sof), 64'(mq[0].x == 0 && mq[0].y == 0));
      check("out_eof", 64'(bus.out_eof), 64'(mq[0].x == SW-1 && mq[0].y == SH-1));
    end else begin
      check("out_sof_idle", 64'(bus.out_sof), 64'd0);
      check("out_eof_idle", 64'(bus.out_eof), 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Raises finished with the given result, holds it over one capture edge,
  // then drops it. Returns 1 time unit after the capture edge.
  task automatic push(input logic [IW-1:0] it, input logic [PW-1:0] x, input logic [PW-1:0] y);
    @(posedge clk); #1;
    bus.finished = 1'b1; bus.iterations = it; bus.xpixel = x; bus.ypixel = y;
    @(posedge clk); #1;
    bus.finished = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.clear      = 1'b0;
    bus.finished   = 1'b1;   // engine power-up value
    bus.iterations = '0;
    bus.xpixel     = '0;
    bus.ypixel     = '0;
    bus.out_ready  = 1'b0;

    // Reset release with finished held high: nothing captured.
    step(2);
    reset = 1'b0;
    step(3);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_full", 64'(bus.full_queue), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    bus.finished = 1'b0;
    step(1);

    // Single result 37/5/9 with out_ready=1: visible one cycle after capture.
    bus.out_ready = 1'b1;
    push(37, 5, 9);
    check("one_valid", 64'(bus.out_valid), 64'd1);
    check("one_it", 64'(bus.out_iterations), 64'd37);
    check("one_x", 64'(bus.out_x), 64'd5);
    check("one_y", 64'(bus.out_y), 64'd9);
    step(1);
    check("one_drained", 64'(bus.count), 64'd0);
    bus.out_ready = 1'b0;

    // Fill: threshold at 14, full at 16, 17th dropped.
    for (int i = 0; i < 13; i++) push(i, i, i + 100);
    check("fill13_full", 64'(bus.full_queue), 64'd0);
    push(13, 13, 113);
    check("fill14_count", 64'(bus.count), 64'd14);
    check("fill14_full", 64'(bus.full_queue), 64'd1);
    push(14, 14, 114);
    push(15, 15, 115);
    check("fill16_count", 64'(bus.count), 64'd16);
    check("fill16_ovf", 64'(bus.overflow), 64'd0);
    push(16, 16, 116);
    check("drop_count", 64'(bus.count), 64'd16);
    check("drop_ovf", 64'(bus.overflow), 64'd1);
    check("drop_head", 64'(bus.out_iterations), 64'd0);

    // Full FIFO with simultaneous push and pop.
    @(posedge clk); #1;
    bus.finished = 1'b1; bus.iterations = 17; bus.xpixel = 17; bus.ypixel = 117;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.finished = 1'b0; bus.out_ready = 1'b0;
    check("pp_count", 64'(bus.count), 64'd16);
    check("pp_head", 64'(bus.out_iterations), 64'd1);
    bus.out_ready = 1'b1;
    step(20);
    bus.out_ready = 1'b0;
    check("pp_drained", 64'(bus.count), 64'd0);
    check("pp_full_off", 64'(bus.full_queue), 64'd0);

    // Frame markers.
    push(3, 0, 0);
    push(4, SW-1, SH-1);
    check("sof_first", 64'(bus.out_sof), 64'd1);
    check("eof_first", 64'(bus.out_eof), 64'd0);
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    check("sof_second", 64'(bus.out_sof), 64'd0);
    check("eof_second", 64'(bus.out_eof), 64'd1);
    check("eof_x", 64'(bus.out_x), 64'(SW-1));
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;

    // Clear with 5 entries and a push in the same cycle.
    for (int i = 0; i < 5; i++) push(50 + i, i, 1);
    check("clr_pre", 64'(bus.count), 64'd5);
    @(posedge clk); #1;
    bus.finished = 1'b1; bus.iterations = 99; bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.finished = 1'b0; bus.clear = 1'b0;
    check("clr_count", 64'(bus.count), 64'd0);
    check("clr_valid", 64'(bus.out_valid), 64'd0);
    check("clr_full", 64'(bus.full_queue), 64'd0);
    check("clr_ovf_kept", 64'(bus.overflow), 64'd1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.finished   = 1'($urandom_range(0, 1));
      bus.iterations = $urandom();
      case ($urandom_range(0, 9))
        0:       begin bus.xpixel = 0;    bus.ypixel = 0;    end
        1:       begin bus.xpixel = SW-1; bus.ypixel = SH-1; end
        default: begin bus.xpixel = $urandom_range(0, SW-1); bus.ypixel = $urandom_range(0, SH-1); end
      endcase
      bus.out_ready = ($urandom_range(0, 3) != 0) ^ (c[9] & c[8]);
      bus.clear     = ($urandom_range(0, 99) == 0);
    end
    bus.clear = 1'b0; bus.finished = 1'b0; bus.out_ready = 1'b0;
    step(1);

    // Asynchronous reset mid-transfer.
    push(7, 1, 2);
    push(8, 3, 4);
    push(9, 5, 6);
    check("mid_pre", 64'(bus.count) != 0, 64'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("mid_valid", 64'(bus.out_valid), 64'd0);
    check("mid_count", 64'(bus.count), 64'd0);
    check("mid_ovf", 64'(bus.overflow), 64'd0);
    step(2);
    reset = 1'b0;
    step(3);
    check("post_count", 64'(bus.count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
